// File: rtl/pcs_lock_ctrl_pkg.sv
// pcs_lock_ctrl_pkg: shared state type and default sizing
// for the 10GBASE-R block-lock / hi-BER controller.
package pcs_lock_ctrl_pkg;

  typedef enum logic [1:0] {
    S_LOCK_INIT,
    S_TEST_SH,
    S_SLIP,
    S_SLIP_WAIT
  } lock_state_t;

  localparam int DEF_SH_CNT_MAX   = 64;
  localparam int DEF_SH_INVLD_MAX = 16;
  localparam int DEF_SLIP_WAIT    = 32;
  localparam int DEF_BER_TIMER    = 39062;
  localparam int DEF_BER_LIMIT    = 16;

endpackage

// File: rtl/pcs_lock_ctrl_ber.sv
// pcs_ber_mon: windowed invalid-header counter raising hi_ber.
// Held cleared while the receiver is not block-locked.
module pcs_ber_mon
  import pcs_lock_ctrl_pkg::*;
#(
  parameter int BER_TIMER = DEF_BER_TIMER,
  parameter int BER_LIMIT = DEF_BER_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic bad,
  output logic hi_ber
);

  localparam int TW = $clog2(BER_TIMER + 1);
  localparam int BW = $clog2(BER_LIMIT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BER_TIMER - 1);
  localparam logic [BW-1:0] LIM    = BW'(BER_LIMIT);
  localparam logic [BW-1:0] LIM_M1 = BW'(BER_LIMIT - 1);

  logic [TW-1:0] timer;
  logic [BW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer  <= '0;
      cnt    <= '0;
      hi_ber <= 1'b0;
    end else if (!en) begin
      timer  <= '0;
      cnt    <= '0;
      hi_ber <= 1'b0;
    end else if (timer == T_LAST) begin
      // a bad header on the wrap cycle opens the new window
      timer <= '0;
      cnt   <= BW'(bad);
      if (cnt != LIM) hi_ber <= 1'b0;
    end else begin
      timer <= timer + 1'b1;
      if (bad && cnt != LIM) begin
        cnt <= cnt + 1'b1;
        if (cnt == LIM_M1) hi_ber <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcs_lock_ctrl.sv
// pcs_lock_ctrl: 66b block-lock FSM with PMA slip sequencing,
// slip counter and hi-BER monitor for the 10GBASE-R RX path.
module pcs_lock_ctrl
  import pcs_lock_ctrl_pkg::*;
#(
  parameter int SH_CNT_MAX   = DEF_SH_CNT_MAX,
  parameter int SH_INVLD_MAX = DEF_SH_INVLD_MAX,
  parameter int SLIP_WAIT    = DEF_SLIP_WAIT,
  parameter int BER_TIMER    = DEF_BER_TIMER,
  parameter int BER_LIMIT    = DEF_BER_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sh_ena,
  input  logic        sh_valid,
  input  logic        force_linkdown,
  output logic        pma_slip,
  output logic        block_lock,
  output logic        hi_ber,
  output logic        link_up,
  output logic [15:0] slip_cnt
);

  localparam int SCW = $clog2(SH_CNT_MAX + 1);
  localparam int ICW = $clog2(SH_INVLD_MAX + 1);
  localparam int WCW = $clog2(SLIP_WAIT + 1);
  localparam logic [SCW-1:0] SH_MAX_C  = SCW'(SH_CNT_MAX);
  localparam logic [ICW-1:0] INV_MAX_C = ICW'(SH_INVLD_MAX);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(SLIP_WAIT - 1);

  lock_state_t    state, state_nx;
  logic [SCW-1:0] sh_cnt, sh_cnt_nx, sh_inc;
  logic [ICW-1:0] invld_cnt, invld_cnt_nx, inv_inc;
  logic [WCW-1:0] wait_cnt, wait_cnt_nx;
  logic           lock_nx;

  always_comb begin
    state_nx     = state;
    sh_cnt_nx    = sh_cnt;
    invld_cnt_nx = invld_cnt;
    wait_cnt_nx  = wait_cnt;
    lock_nx      = block_lock;
    sh_inc       = sh_cnt + 1'b1;
    inv_inc      = invld_cnt + ICW'(!sh_valid);
    unique case (state)
      S_LOCK_INIT: begin
        lock_nx      = 1'b0;
        sh_cnt_nx    = '0;
        invld_cnt_nx = '0;
        state_nx     = S_TEST_SH;
      end
      S_TEST_SH: begin
        if (sh_ena) begin
          sh_cnt_nx    = sh_inc;
          invld_cnt_nx = inv_inc;
          if ((!block_lock && !sh_valid) ||
              (block_lock && inv_inc == INV_MAX_C)) begin
            state_nx     = S_SLIP;
            lock_nx      = 1'b0;
            sh_cnt_nx    = '0;
            invld_cnt_nx = '0;
          end else if (sh_inc == SH_MAX_C) begin
            if (inv_inc == '0) lock_nx = 1'b1;
            sh_cnt_nx    = '0;
            invld_cnt_nx = '0;
          end
        end
      end
      S_SLIP: begin
        lock_nx     = 1'b0;
        wait_cnt_nx = '0;
        state_nx    = S_SLIP_WAIT;
      end
      S_SLIP_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nx = S_LOCK_INIT;
        else wait_cnt_nx = wait_cnt + 1'b1;
      end
      default: state_nx = S_LOCK_INIT;
    endcase
    // linkdown beats any same-cycle verdict and never slips
    if (force_linkdown) begin
      state_nx     = S_LOCK_INIT;
      lock_nx      = 1'b0;
      sh_cnt_nx    = '0;
      invld_cnt_nx = '0;
      wait_cnt_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOCK_INIT;
      sh_cnt     <= '0;
      invld_cnt  <= '0;
      wait_cnt   <= '0;
      block_lock <= 1'b0;
      pma_slip   <= 1'b0;
      slip_cnt   <= '0;
      link_up    <= 1'b0;
    end else begin
      state      <= state_nx;
      sh_cnt     <= sh_cnt_nx;
      invld_cnt  <= invld_cnt_nx;
      wait_cnt   <= wait_cnt_nx;
      block_lock <= lock_nx;
      pma_slip   <= (state_nx == S_SLIP);
      if (state_nx == S_SLIP && slip_cnt != 16'hFFFF)
        slip_cnt <= slip_cnt + 16'd1;
      link_up    <= block_lock & ~hi_ber;
    end
  end

  pcs_ber_mon #(
    .BER_TIMER (BER_TIMER),
    .BER_LIMIT (BER_LIMIT)
  ) u_ber (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (block_lock & ~force_linkdown),
    .bad    (sh_ena & ~sh_valid),
    .hi_ber (hi_ber)
  );

endmodule

// File: tb/tb_pcs_lock_ctrl.sv
// tb_pcs_lock_ctrl: scenario tasks plus randomized traffic,
// checked against a header-counting reference model.
module tb_pcs_lock_ctrl;

  localparam int SH_MAX  = 64;
  localparam int INV_MAX = 16;
  localparam int WAIT    = 32;
  localparam int BT      = 2000;
  localparam int BL      = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sh_ena = 1'b0;
  logic sh_valid = 1'b0;
  logic force_linkdown = 1'b0;
  logic pma_slip, block_lock, hi_ber, link_up;
  logic [15:0] slip_cnt;

  int errors = 0;
  int checks = 0;

  bit m_lock, m_hi, m_link, m_slip;
  logic [15:0] m_slips;
  int m_hdr, m_inv, m_blind, m_age, m_bcnt;
  bit ol, oh, bad;

  logic [19:0] dut_v, mdl_v;
  assign dut_v = {block_lock, hi_ber, link_up, pma_slip, slip_cnt};
  assign mdl_v = {m_lock, m_hi, m_link, m_slip, m_slips};

  pcs_lock_ctrl #(.BER_TIMER(BT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sh_ena         (sh_ena),
    .sh_valid       (sh_valid),
    .force_linkdown (force_linkdown),
    .pma_slip       (pma_slip),
    .block_lock     (block_lock),
    .hi_ber         (hi_ber),
    .link_up        (link_up),
    .slip_cnt       (slip_cnt)
  );

  always #5 clk = ~clk;

  // headers are blind for 1 edge after reset/linkdown and 34 after a slip
  task automatic model_reset();
    m_lock = 0; m_hi = 0; m_link = 0; m_slip = 0; m_slips = '0;
    m_hdr = 0; m_inv = 0; m_blind = 1; m_age = 0; m_bcnt = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    ol = m_lock; oh = m_hi;
    bad = sh_ena && !sh_valid;
    m_link = ol && !oh;
    m_slip = 0;
    if (force_linkdown) begin
      m_lock = 0; m_hdr = 0; m_inv = 0; m_blind = 1;
    end else if (m_blind > 0) begin
      m_blind--;
    end else if (sh_ena) begin
      m_hdr++;
      if (!sh_valid) m_inv++;
      if ((!ol && !sh_valid) || (ol && m_inv >= INV_MAX)) begin
        m_slip = 1; m_lock = 0; m_hdr = 0; m_inv = 0;
        m_blind = WAIT + 2;
        if (m_slips != 16'hFFFF) m_slips++;
      end else if (m_hdr == SH_MAX) begin
        if (m_inv == 0) m_lock = 1;
        m_hdr = 0; m_inv = 0;
      end
    end
    if (force_linkdown || !ol) begin
      m_age = 0; m_bcnt = 0; m_hi = 0;
    end else if (m_age == BT - 1) begin
      m_age = 0;
      if (m_bcnt < BL) m_hi = 0;
      m_bcnt = bad ? 1 : 0;
    end else begin
      m_age++;
      if (bad && m_bcnt < BL) begin
        m_bcnt++;
        if (m_bcnt == BL) m_hi = 1;
      end
    end
  endtask

  task automatic cyc(input logic e, input logic v, input logic f);
    sh_ena = e; sh_valid = v; force_linkdown = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic lock_up(input string tag);
    int sent;
    logic e;
    sent = 0;
    repeat (WAIT + 4) begin
      cyc(0, 0, 0);
      checks++;
      if (dut_v !== mdl_v) begin errors++; $display("FAIL %s_idle t=%0t dut=%h model=%h", tag, $time, dut_v, mdl_v); end
    end
    for (int n = 0; n < 2000 && sent < SH_MAX; n++) begin
      e = ($urandom_range(3) != 0);
      cyc(e, 1, 0);
      if (e) sent++;
      checks++;
      if (dut_v !== mdl_v) begin errors++; $display("FAIL %s_feed t=%0t dut=%h model=%h", tag, $time, dut_v, mdl_v); end
    end
    checks++;
    if (block_lock !== 1'b1 || sent != SH_MAX) begin errors++; $display("FAIL %s_lock got=%b sent=%0d want lock=1", tag, block_lock, sent); end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) cyc(1, 0, 0);
    checks++;
    if (dut_v !== 20'h0) begin errors++; $display("FAIL reset_outputs got=%h want=0", dut_v); end
    rst_n = 1'b1;
    cyc(0, 0, 0);
    checks++;
    if (dut_v !== mdl_v) begin errors++; $display("FAIL reset_release dut=%h model=%h", dut_v, mdl_v); end
  endtask

  task automatic test_lock();
    int sent;
    logic e;
    sent = 0;
    for (int n = 0; n < 1000 && sent < SH_MAX; n++) begin
      e = ($urandom_range(3) != 0);
      cyc(e, 1, 0);
      if (e) sent++;
      checks++;
      if (dut_v !== mdl_v || pma_slip !== 1'b0) begin errors++; $display("FAIL lock_feed t=%0t dut=%h model=%h", $time, dut_v, mdl_v); end
    end
    checks++;
    if (block_lock !== 1'b1) begin errors++; $display("FAIL lock_after_64 got=%b want=1", block_lock); end
    cyc(0, 0, 0);
    checks++;
    if (link_up !== 1'b1 || slip_cnt !== 16'd0) begin errors++; $display("FAIL lock_link_up got=%b/%0d want=1/0", link_up, slip_cnt); end
  endtask

  task automatic test_slip();
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    checks++;
    if (pma_slip !== 1'b1 || slip_cnt !== 16'd1 || block_lock !== 1'b0) begin errors++; $display("FAIL slip_pulse got slip=%b cnt=%0d lock=%b want 1/1/0", pma_slip, slip_cnt, block_lock); end
    repeat (WAIT + 2) begin
      cyc(1, 0, 0);
      checks++;
      if (pma_slip !== 1'b0 || slip_cnt !== 16'd1 || dut_v !== mdl_v) begin errors++; $display("FAIL slip_blind t=%0t dut=%h model=%h", $time, dut_v, mdl_v); end
    end
    for (int i = 0; i < SH_MAX; i++) begin
      cyc(1, 1, 0);
      checks++;
      if (dut_v !== mdl_v) begin errors++; $display("FAIL slip_relock t=%0t dut=%h model=%h", $time, dut_v, mdl_v); end
    end
    checks++;
    if (block_lock !== 1'b1) begin errors++; $display("FAIL slip_relock_lock got=%b want=1", block_lock); end
  endtask

  task automatic test_invalid_window();
    bit pos[SH_MAX];
    int k, p, nbad;
    logic [15:0] sc0;
    sc0 = slip_cnt;
    for (int w = 0; w < 2; w++) begin
      foreach (pos[i]) pos[i] = 0;
      k = 0;
      while (k < INV_MAX - 1 + w) begin
        p = $urandom_range(SH_MAX - 1);
        if (!pos[p]) begin pos[p] = 1; k++; end
      end
      nbad = 0;
      for (int i = 0; i < SH_MAX && nbad < INV_MAX; i++) begin
        cyc(1, !pos[i], 0);
        if (pos[i]) nbad++;
        checks++;
        if (dut_v !== mdl_v) begin errors++; $display("FAIL invwin%0d t=%0t dut=%h model=%h", w, $time, dut_v, mdl_v); end
      end
      if (w == 0) begin
        checks++;
        if (block_lock !== 1'b1 || slip_cnt !== sc0) begin errors++; $display("FAIL invwin_15_hold lock=%b cnt=%0d want 1/%0d", block_lock, slip_cnt, sc0); end
      end
    end
    checks++;
    if (pma_slip !== 1'b1 || block_lock !== 1'b0 || slip_cnt !== sc0 + 16'd1) begin errors++; $display("FAIL invwin_16_slip slip=%b lock=%b cnt=%0d want 1/0/%0d", pma_slip, block_lock, slip_cnt, sc0 + 16'd1); end
  endtask

  task automatic test_hi_ber();
    bit pos[SH_MAX];
    int k, p, n;
    lock_up("hiber_pre");
    for (int w = 0; w < 4; w++) begin
      foreach (pos[i]) pos[i] = 0;
      k = 0;
      while (k < 4) begin
        p = $urandom_range(SH_MAX - 1);
        if (!pos[p]) begin pos[p] = 1; k++; end
      end
      for (int i = 0; i < SH_MAX; i++) begin
        cyc(1, !pos[i], 0);
        checks++;
        if (dut_v !== mdl_v) begin errors++; $display("FAIL hiber_feed t=%0t dut=%h model=%h", $time, dut_v, mdl_v); end
      end
    end
    checks++;
    if (hi_ber !== 1'b1 || block_lock !== 1'b1) begin errors++; $display("FAIL hiber_set hi=%b lock=%b want 1/1", hi_ber, block_lock); end
    cyc(0, 0, 0);
    checks++;
    if (link_up !== 1'b0) begin errors++; $display("FAIL hiber_link_down got=%b want=0", link_up); end
    n = 0;
    while (hi_ber === 1'b1 && n < 3 * BT) begin
      cyc(0, 0, 0);
      n++;
      checks++;
      if (dut_v !== mdl_v) begin errors++; $display("FAIL hiber_idle t=%0t dut=%h model=%h", $time, dut_v, mdl_v); end
    end
    checks++;
    if (hi_ber !== 1'b0 || n < BT) begin errors++; $display("FAIL hiber_clear hi=%b after %0d cycles want 0 after >=%0d", hi_ber, n, BT); end
    cyc(0, 0, 0);
    checks++;
    if (link_up !== 1'b1) begin errors++; $display("FAIL hiber_link_back got=%b want=1", link_up); end
  endtask

  task automatic test_force();
    logic [15:0] sc0;
    sc0 = slip_cnt;
    cyc(1, 0, 1);
    checks++;
    if (block_lock !== 1'b0 || pma_slip !== 1'b0) begin errors++; $display("FAIL force_drop lock=%b slip=%b want 0/0", block_lock, pma_slip); end
    repeat (5) begin
      cyc(0, 0, 0);
      checks++;
      if (pma_slip !== 1'b0 || slip_cnt !== sc0 || dut_v !== mdl_v) begin errors++; $display("FAIL force_noslip t=%0t dut=%h model=%h", $time, dut_v, mdl_v); end
    end
    lock_up("force_relock");
  endtask

  task automatic test_reset_mid_slip();
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pma_slip !== 1'b0 || slip_cnt !== 16'd0) begin errors++; $display("FAIL rst_in_slip slip=%b cnt=%0d want 0/0", pma_slip, slip_cnt); end
    cyc(0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    checks++;
    if (pma_slip !== 1'b1 || slip_cnt !== 16'd1) begin errors++; $display("FAIL rst_reslip slip=%b cnt=%0d want 1/1", pma_slip, slip_cnt); end
    repeat (10) cyc(1, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_v !== 20'h0) begin errors++; $display("FAIL rst_in_wait got=%h want=0", dut_v); end
    repeat (3) cyc(1, 0, 0);
    rst_n = 1'b1;
    lock_up("rst_relock");
    checks++;
    if (slip_cnt !== 16'd0 || pma_slip !== 1'b0) begin errors++; $display("FAIL rst_relock_cnt cnt=%0d slip=%b want 0/0", slip_cnt, pma_slip); end
  endtask

  task automatic test_random();
    int thr;
    for (int n = 0; n < 4000; n++) begin
      thr = (n < 2000) ? 3 : 40;
      cyc($urandom_range(1), ($urandom_range(999) >= thr), ($urandom_range(299) == 0));
      checks++;
      if (dut_v !== mdl_v) begin errors++; $display("FAIL random t=%0t dut=%h model=%h", $time, dut_v, mdl_v); end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slip();
    test_invalid_window();
    test_hi_ber();
    test_force();
    test_reset_mid_slip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
